// File: rtl/qblock_sprite_renderer.sv
// ----------------------------------------------------------------------------
// qblock_sprite_renderer
//
// Drives the question-block blink ROMs and turns their palette output into a
// pixel/hit pair for the frame compositor.
//
//   * Address stage (S1): the scan position (draw_x/draw_y) relative to the
//     block's top-left corner becomes a linear ROM address row*SPRITE_W+col.
//     The address is 0 whenever the pixel falls outside the sprite box.
//   * Colour stage (S2): the ROM colour is registered.  The transparent
//     KEY_COLOR, and anything outside the box, gives pix_hit=0 and
//     pix_color=0.
//   * Animation: a ping-pong blink 0,1,2,1,0,... over the three blink ROMs.
//     Each frame is held for FRAME_TICKS frame_start pulses.
//
// Pixel handshake: pix_valid qualifies draw_x/draw_y in the same cycle.
// pix_out_valid qualifies pix_hit/pix_color exactly two cycles later.
// There is no ready/back-pressure, so a pixel is never stalled or dropped
// except by Reset.
//
// Optional feature: define QBLOCK_BOUNCE_EN to enable the bump bounce.  A bump
// lifts the sprite by BUMP_PX pixels for BUMP_FRAMES frame_start pulses.
// Without the macro, bump is ignored.
//
// Ports
//   Clk, Reset      clock; synchronous active-high reset
//   frame_start     one-cycle pulse at start of vertical blank
//   block_active    1 = animate, 0 = show frame 0 and hold
//   bump            one-cycle hit pulse (bounce build only)
//   block_x/y       sprite top-left position
//   pix_valid       draw_x/draw_y valid this cycle
//   draw_x/y        current scan position
//   rom_addr        address to the blink ROMs
//   frame_sel       blink ROM select (0,1,2) for the external colour mux
//   rom_color       colour from the selected ROM (async read of rom_addr)
//   pix_out_valid   pix_hit/pix_color valid
//   pix_hit         pixel inside sprite and not transparent
//   pix_color       sprite colour, 0 when pix_hit=0
//   dbg_state       animation FSM state, for debug visibility
// ----------------------------------------------------------------------------
module qblock_sprite_renderer #(
    parameter int          SPRITE_W    = 20,
    parameter int          SPRITE_H    = 20,
    parameter int          FRAME_TICKS = 8,
    parameter logic [11:0] KEY_COLOR   = 12'h808,
    parameter int          BUMP_PX     = 4,
    parameter int          BUMP_FRAMES = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        block_active,
    input  logic        bump,
    input  logic [9:0]  block_x,
    input  logic [9:0]  block_y,
    input  logic        pix_valid,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic [8:0]  rom_addr,
    output logic [1:0]  frame_sel,
    input  logic [11:0] rom_color,
    output logic        pix_out_valid,
    output logic        pix_hit,
    output logic [11:0] pix_color,
    output logic [1:0]  dbg_state
);

    // ------------------------------------------------------------------
    // Animation FSM encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;

    // The tick counter must stay at least one bit wide when FRAME_TICKS == 1.
    localparam int              TICK_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);

    logic [1:0]        state;
    logic [TICK_W-1:0] tick;

    // ------------------------------------------------------------------
    // Effective sprite y (with optional bounce lift)
    // ------------------------------------------------------------------
    logic [9:0] eff_y;

`ifdef QBLOCK_BOUNCE_EN
    localparam int BNC_W = $clog2(BUMP_FRAMES + 1);

    logic [BNC_W-1:0] bounce_cnt;

    // A bump only starts a bounce from rest.  A load has priority over the
    // decrement, so a bump that lands on a frame_start gets its full length.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bounce_cnt <= '0;
        end else if (bump && (bounce_cnt == '0)) begin
            bounce_cnt <= BNC_W'(BUMP_FRAMES);
        end else if (frame_start && (bounce_cnt != '0)) begin
            bounce_cnt <= bounce_cnt - BNC_W'(1);
        end
    end

    // The lift saturates at the top of the screen instead of wrapping.
    always_comb begin
        eff_y = block_y;
        if (bounce_cnt != '0) begin
            eff_y = (block_y >= 10'(BUMP_PX)) ? (block_y - 10'(BUMP_PX)) : 10'd0;
        end
    end
`else
    // Bounce hardware is absent.  These names mark the inputs and parameters
    // as deliberately unused in this build.
    logic unused_bump;
    localparam int unused_bump_cfg = BUMP_PX + BUMP_FRAMES;

    assign unused_bump = bump;
    assign eff_y       = block_y;
`endif

    // ------------------------------------------------------------------
    // S1: box test and linear address
    // ------------------------------------------------------------------
    // The offsets are 11-bit two's complement.  A negative offset (bit 10 set)
    // means the scan is left of or above the sprite.
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_box_c;
    logic [8:0]  lin_addr;

    assign dx = {1'b0, draw_x} - {1'b0, block_x};
    assign dy = {1'b0, draw_y} - {1'b0, eff_y};

    assign in_box_c = !dx[10] && (dx[9:0] < 10'(SPRITE_W)) &&
                      !dy[10] && (dy[9:0] < 10'(SPRITE_H));

    // The product is only meaningful inside the box, where it stays below
    // SPRITE_W*SPRITE_H.  Otherwise the address is forced to 0 below.
    assign lin_addr = 9'(int'(dy[9:0]) * SPRITE_W + int'(dx[9:0]));

    logic s1_valid;
    logic s1_in_box;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr  <= '0;
            s1_valid  <= 1'b0;
            s1_in_box <= 1'b0;
        end else begin
            rom_addr  <= in_box_c ? lin_addr : 9'd0;
            s1_valid  <= pix_valid;
            s1_in_box <= in_box_c;
        end
    end

    // ------------------------------------------------------------------
    // S2: colour register with transparency key
    // ------------------------------------------------------------------
    // rom_color is the asynchronous read of the registered rom_addr, so it
    // belongs to the pixel currently held in S1.
    logic hit_c;

    assign hit_c = s1_valid && s1_in_box && (rom_color != KEY_COLOR);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_out_valid <= 1'b0;
            pix_hit       <= 1'b0;
            pix_color     <= '0;
        end else begin
            pix_out_valid <= s1_valid;
            pix_hit       <= hit_c;
            pix_color     <= hit_c ? rom_color : 12'h000;
        end
    end

    // ------------------------------------------------------------------
    // Animation FSM
    // ------------------------------------------------------------------
    // Dropping block_active returns to frame 0 at once, without waiting for
    // blanking.  Otherwise the FSM only moves on frame_start.
    //
    // S_IDLE treats its first frame_start like an S_UP step.  That pulse
    // therefore already counts toward holding frame 0.
    always_ff @(posedge Clk) begin
        if (Reset || !block_active) begin
            state     <= S_IDLE;
            tick      <= '0;
            frame_sel <= 2'd0;
        end else if (frame_start) begin
            if (tick == TICK_LAST) begin
                tick <= '0;
                if (state == S_DOWN) begin
                    frame_sel <= frame_sel - 2'd1;
                    state     <= (frame_sel == 2'd1) ? S_UP : S_DOWN;
                end else begin
                    frame_sel <= frame_sel + 2'd1;
                    state     <= (frame_sel == 2'd1) ? S_DOWN : S_UP;
                end
            end else begin
                tick <= tick + TICK_W'(1);
                if (state == S_IDLE) begin
                    state <= S_UP;
                end
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_qblock_sprite_renderer.sv
// ----------------------------------------------------------------------------
// tb_qblock_sprite_renderer
//
// Bench for qblock_sprite_renderer.  The design is built with FRAME_TICKS=2.
// A behavioural ROM model feeds rom_color from rom_addr and frame_sel.
//
// The expected pixel results come from the sprite rules, written directly:
// offset from the block, box test, address row*20+col, transparency key.
// The expected blink frame is the pulse count since activation, indexed into
// the ping-pong sequence 0,1,2,1.
//
// Bounce checks are compiled only when QBLOCK_BOUNCE_EN is defined.
// ----------------------------------------------------------------------------
module tb_qblock_sprite_renderer;

    localparam int          FT      = 2;
    localparam int          SW      = 20;
    localparam int          SH      = 20;
    localparam logic [11:0] KEY     = 12'h808;
    localparam int          B_PX    = 4;
    localparam int          B_FRM   = 6;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        Reset;
    logic        frame_start;
    logic        block_active;
    logic        bump;
    logic [9:0]  block_x;
    logic [9:0]  block_y;
    logic        pix_valid;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [8:0]  rom_addr;
    logic [1:0]  frame_sel;
    logic [11:0] rom_color;
    logic        pix_out_valid;
    logic        pix_hit;
    logic [11:0] pix_color;
    logic [1:0]  dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    qblock_sprite_renderer #(
        .SPRITE_W(SW), .SPRITE_H(SH), .FRAME_TICKS(FT),
        .KEY_COLOR(KEY), .BUMP_PX(B_PX), .BUMP_FRAMES(B_FRM)
    ) dut (
        .Clk(clk), .Reset(Reset), .frame_start(frame_start),
        .block_active(block_active), .bump(bump),
        .block_x(block_x), .block_y(block_y),
        .pix_valid(pix_valid), .draw_x(draw_x), .draw_y(draw_y),
        .rom_addr(rom_addr), .frame_sel(frame_sel), .rom_color(rom_color),
        .pix_out_valid(pix_out_valid), .pix_hit(pix_hit),
        .pix_color(pix_color), .dbg_state(dbg_state)
    );

    // ---------------- ROM model ----------------
    logic        force_en;
    logic [11:0] force_val;

    function automatic logic [11:0] rom_fn(input logic [8:0] a, input logic [1:0] f);
        int v;
        if ((int'(a) % 7) == 3) return 12'h808;
        v = (int'(a) * 37 + int'(f) * 523 + 1) % 4096;
        return 12'(v);
    endfunction

    assign rom_color = force_en ? force_val : rom_fn(rom_addr, frame_sel);

    // ---------------- reference model state ----------------
    logic       m_active;
    int         m_pulses;
    logic [1:0] m_frame;
    int         m_bounce;

    int n_checks;
    int n_errors;

    // Expected entry: {valid, hit, addr[8:0], color[11:0]}
    logic [22:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] pingpong(input int pulses);
        int idx;
        idx = (pulses / FT) % 4;
        return (idx == 3) ? 2'd1 : 2'(idx);
    endfunction

    function automatic logic [22:0] model_pix(input logic v, input int x, input int y);
        int ey, dx, dy, addr;
        logic inb, hit;
        logic [11:0] col, pc;
        ey = int'(block_y);
        if (m_bounce > 0) ey = (ey >= B_PX) ? ey - B_PX : 0;
        dx   = x - int'(block_x);
        dy   = y - ey;
        inb  = (dx >= 0) && (dx < SW) && (dy >= 0) && (dy < SH);
        addr = inb ? dy * SW + dx : 0;
        col  = force_en ? force_val : rom_fn(9'(addr), m_frame);
        hit  = v && inb && (col != KEY);
        pc   = hit ? col : 12'h000;
        return {v, hit, 9'(addr), pc};
    endfunction

    // ---------------- driver tasks ----------------
    // One pixel per cycle.  rom_addr is checked one cycle later and the
    // colour-stage outputs two cycles later.
    task automatic pix_cycle(input logic v, input int x, input int y);
        logic [22:0] e;
        @(posedge clk); #1;
        pix_valid = v;
        draw_x    = 10'(x);
        draw_y    = 10'(y);
        exp_q.push_back(model_pix(v, x, y));
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            e = exp_q[exp_q.size() - 2];
            if (e[22]) check_val("rom_addr", 32'(rom_addr), 32'(e[20:12]));
        end
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            check_val("pix_out_valid", 32'(pix_out_valid), 32'(e[22]));
            check_val("pix_hit",       32'(pix_hit),       32'(e[21]));
            check_val("pix_color",     32'(pix_color),     32'(e[11:0]));
        end
    endtask

    task automatic flush();
        pix_cycle(1'b0, 0, 0);
        pix_cycle(1'b0, 0, 0);
        exp_q.delete();
    endtask

    task automatic frame_pulse();
        @(posedge clk); #1;
        pix_valid   = 1'b0;
        frame_start = 1'b1;
        if (m_active) begin
            m_pulses++;
            m_frame = pingpong(m_pulses);
        end
        if (m_bounce > 0) m_bounce--;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        check_val("frame_sel", 32'(frame_sel), 32'(m_frame));
    endtask

    task automatic set_active(input logic v);
        @(posedge clk); #1;
        block_active = v;
        m_active     = v;
        m_pulses     = 0;
        m_frame      = 2'd0;
        @(posedge clk);
        @(negedge clk);
        if (!v) check_val("frame_sel_deact", 32'(frame_sel), 32'd0);
    endtask

    task automatic do_bump();
        @(posedge clk); #1;
        bump = 1'b1;
        if (m_bounce == 0) m_bounce = B_FRM;
        @(posedge clk); #1;
        bump = 1'b0;
    endtask

    task automatic set_block(input int x, input int y);
        @(posedge clk); #1;
        block_x = 10'(x);
        block_y = 10'(y);
    endtask

    function automatic int clamp10(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0; n_errors = 0;
        Reset = 1'b1; frame_start = 1'b0; block_active = 1'b0; bump = 1'b0;
        block_x = '0; block_y = '0; pix_valid = 1'b0; draw_x = '0; draw_y = '0;
        force_en = 1'b0; force_val = '0;
        m_active = 1'b0; m_pulses = 0; m_frame = 2'd0; m_bounce = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_rom_addr",  32'(rom_addr),      32'd0);
        check_val("rst_frame_sel", 32'(frame_sel),     32'd0);
        check_val("rst_out_valid", 32'(pix_out_valid), 32'd0);
        check_val("rst_pix_hit",   32'(pix_hit),       32'd0);
        check_val("rst_pix_color", 32'(pix_color),     32'd0);
        @(posedge clk); #1;
        Reset = 1'b0;

        // Directed corners and edges of the box at (100,50).
        set_block(100, 50);
        pix_cycle(1'b1, 100, 50);
        pix_cycle(1'b1, 119, 69);
        pix_cycle(1'b1, 120, 69);
        pix_cycle(1'b1, 99, 50);
        pix_cycle(1'b1, 100, 69);
        pix_cycle(1'b1, 119, 50);
        pix_cycle(1'b1, 110, 70);
        pix_cycle(1'b0, 105, 55);
        pix_cycle(1'b1, 110, 60);
        flush();

        // Transparent key versus an opaque colour.
        force_en = 1'b1; force_val = 12'h808;
        pix_cycle(1'b1, 105, 55);
        flush();
        force_val = 12'hE51;
        pix_cycle(1'b1, 105, 55);
        pix_cycle(1'b1, 130, 55);
        flush();
        force_en = 1'b0;

        // Ping-pong blink, then immediate return to frame 0.
        set_active(1'b1);
        for (int i = 0; i < 10; i++) frame_pulse();
        set_active(1'b0);

        // Randomized blocks and scans while the blink advances.
        set_active(1'b1);
        for (int s = 0; s < 8; s++) begin
            int bx, by, np;
            bx = int'($urandom_range(0, 1010));
            by = int'($urandom_range(0, 1010));
            set_block(bx, by);
            np = int'($urandom_range(0, 3));
            for (int p = 0; p < np; p++) frame_pulse();
            for (int k = 0; k < 40; k++) begin
                int x, y;
                logic v;
                v = ($urandom_range(0, 99) < 85);
                if ($urandom_range(0, 9) < 7) begin
                    x = clamp10(bx + int'($urandom_range(0, 24)) - 3);
                    y = clamp10(by + int'($urandom_range(0, 24)) - 3);
                end else begin
                    x = int'($urandom_range(0, 1023));
                    y = int'($urandom_range(0, 1023));
                end
                pix_cycle(v, x, y);
            end
            flush();
        end
        set_active(1'b0);

        // Reset with pixels in flight and the blink away from frame 0.
        set_active(1'b1);
        set_block(100, 50);
        frame_pulse();
        frame_pulse();
        @(posedge clk); #1;
        pix_valid = 1'b1; draw_x = 10'd105; draw_y = 10'd55;
        @(posedge clk); #1;
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_out_valid", 32'(pix_out_valid), 32'd0);
        check_val("midrst_frame_sel", 32'(frame_sel),     32'd0);
        check_val("midrst_rom_addr",  32'(rom_addr),      32'd0);
        @(posedge clk); #1;
        Reset = 1'b0; pix_valid = 1'b0;
        m_pulses = 0; m_frame = 2'd0; m_bounce = 0;
        frame_pulse();
        frame_pulse();
        frame_pulse();
        set_active(1'b0);

`ifdef QBLOCK_BOUNCE_EN
        // Bounce: a row just above the block is inside only while lifted.
        set_block(200, 100);
        do_bump();
        for (int f = 0; f < 9; f++) begin
            pix_cycle(1'b1, 205, 96);
            pix_cycle(1'b1, 205, 115);
            flush();
            if (f == 2) do_bump();
            frame_pulse();
        end
        set_block(200, 2);
        do_bump();
        pix_cycle(1'b1, 205, 0);
        pix_cycle(1'b1, 205, 19);
        flush();
        for (int f = 0; f < B_FRM; f++) frame_pulse();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
